// File: rtl/amo_sequencer.sv
// amo_sequencer: multicycle control for RV32A LR.W / SC.W / AMO*.W.
// Walks IDLE -> READ -> WRITE -> WB. The LR/SC reservation register lives here.
// Optional feature macro: AMO_LRSC_TIMEOUT_EN. When defined, a reservation expires
// RSV_TIMEOUT cycles after the LR sets it.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 2
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif
`ifndef ALU_OP_AMO
`define ALU_OP_AMO 2'd3
`endif
`ifndef AMO_OP_WIDTH
`define AMO_OP_WIDTH 4
`endif
`ifndef AMO_OP_ADD_W
`define AMO_OP_ADD_W  4'd0
`define AMO_OP_SWAP_W 4'd1
`define AMO_OP_LR_W   4'd2
`define AMO_OP_SC_W   4'd3
`define AMO_OP_XOR_W  4'd4
`define AMO_OP_OR_W   4'd5
`define AMO_OP_AND_W  4'd6
`define AMO_OP_MIN_W  4'd7
`define AMO_OP_MAX_W  4'd8
`define AMO_OP_MINU_W 4'd9
`define AMO_OP_MAXU_W 4'd10
`endif

module amo_sequencer #(
   parameter int unsigned RSV_TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic [4:0]               funct5,
   input  logic [31:0]              addr,
   input  logic                     mem_ready,
   input  logic                     snoop_valid,
   input  logic [31:0]              snoop_addr,
   input  logic                     flush,
   output logic                     busy,
   output logic                     done,
   output logic                     illegal,
   output logic                     misaligned,
   output logic                     mem_valid,
   output logic [3:0]               mem_wstrb,
   output logic                     load_tmp,
   output logic [`ALU_OP_WIDTH-1:0] ALUOp,
   output logic [`AMO_OP_WIDTH-1:0] AMOop,
   output logic                     rd_we,
   output logic                     rd_sel_sc,
   output logic                     sc_fail
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StWb} state_e;

   state_e                    state_q, state_d;
   logic [`AMO_OP_WIDTH-1:0]  op_q, op_d;
   logic [31:2]               addr_q, addr_d;
   logic                      sc_fail_q, sc_fail_d;
   logic                      illegal_q, illegal_d;
   logic                      misaligned_q, misaligned_d;
   logic                      rsv_valid_q, rsv_valid_d;
   logic [31:2]               rsv_addr_q, rsv_addr_d;

   logic                      dec_legal;
   logic [`AMO_OP_WIDTH-1:0]  dec_op;
   logic                      rsv_hit;
   logic                      lr_set;
   logic                      sc_leave;

`ifdef AMO_LRSC_TIMEOUT_EN
   localparam int unsigned CntW = (RSV_TIMEOUT > 1) ? $clog2(RSV_TIMEOUT + 1) : 1;
   logic [CntW-1:0]           cnt_q, cnt_d;
`else
   logic                      unused_timeout;
   assign unused_timeout = ^RSV_TIMEOUT;
`endif

   // Word-granular snoop matching; byte offset bits do not matter.
   logic unused_snoop_bits;
   assign unused_snoop_bits = ^snoop_addr[1:0];

   // Decode funct5 into the AMOop encoding and flag undefined codes.
   always_comb begin
      dec_legal = 1'b1;
      dec_op    = `AMO_OP_ADD_W;
      case (funct5)
         5'b00000: dec_op = `AMO_OP_ADD_W;
         5'b00001: dec_op = `AMO_OP_SWAP_W;
         5'b00010: dec_op = `AMO_OP_LR_W;
         5'b00011: dec_op = `AMO_OP_SC_W;
         5'b00100: dec_op = `AMO_OP_XOR_W;
         5'b01000: dec_op = `AMO_OP_OR_W;
         5'b01100: dec_op = `AMO_OP_AND_W;
         5'b10000: dec_op = `AMO_OP_MIN_W;
         5'b10100: dec_op = `AMO_OP_MAX_W;
         5'b11000: dec_op = `AMO_OP_MINU_W;
         5'b11100: dec_op = `AMO_OP_MAXU_W;
         default:  dec_legal = 1'b0;
      endcase
   end

   // SC succeeds only against a live reservation on the same word.
   assign rsv_hit = rsv_valid_q && (addr[31:2] == rsv_addr_q);

   // Next-state and output decode for the sequencer FSM.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      sc_fail_d    = sc_fail_q;
      illegal_d    = 1'b0;
      misaligned_d = 1'b0;
      lr_set       = 1'b0;
      sc_leave     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      mem_valid    = 1'b0;
      mem_wstrb    = 4'h0;
      load_tmp     = 1'b0;
      ALUOp        = `ALU_OP_ADD;
      AMOop        = `AMO_OP_ADD_W;
      rd_we        = 1'b0;
      rd_sel_sc    = 1'b0;
      sc_fail      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (!dec_legal) begin
                  illegal_d = 1'b1;
               end else if (addr[1:0] != 2'b00) begin
                  misaligned_d = 1'b1;
               end else begin
                  op_d   = dec_op;
                  addr_d = addr[31:2];
                  if (dec_op == `AMO_OP_SC_W) begin
                     sc_leave  = 1'b1;
                     sc_fail_d = !rsv_hit;
                     state_d   = rsv_hit ? StWrite : StWb;
                  end else begin
                     state_d = StRead;
                  end
               end
            end
         end
         StRead: begin
            busy      = 1'b1;
            mem_valid = 1'b1;
            AMOop     = op_q;
            if (mem_ready) begin
               load_tmp = 1'b1;
               if (op_q == `AMO_OP_LR_W) begin
                  lr_set  = 1'b1;
                  state_d = StWb;
               end else begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            busy      = 1'b1;
            mem_valid = 1'b1;
            mem_wstrb = 4'hF;
            ALUOp     = `ALU_OP_AMO;
            AMOop     = op_q;
            if (mem_ready) begin
               state_d = StWb;
               if (op_q == `AMO_OP_SC_W) sc_fail_d = 1'b0;
            end
         end
         StWb: begin
            busy      = 1'b1;
            done      = 1'b1;
            rd_we     = 1'b1;
            AMOop     = op_q;
            rd_sel_sc = (op_q == `AMO_OP_SC_W);
            sc_fail   = (op_q == `AMO_OP_SC_W) && sc_fail_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign illegal    = illegal_q;
   assign misaligned = misaligned_q;

   // Reservation update; later assignments take priority (invalidation beats set).
   always_comb begin
      rsv_valid_d = rsv_valid_q;
      rsv_addr_d  = rsv_addr_q;
`ifdef AMO_LRSC_TIMEOUT_EN
      cnt_d = cnt_q;
      if (rsv_valid_q) begin
         if (cnt_q <= CntW'(1)) rsv_valid_d = 1'b0;
         if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
`endif
      if (lr_set) begin
         rsv_valid_d = 1'b1;
         rsv_addr_d  = addr_q;
`ifdef AMO_LRSC_TIMEOUT_EN
         cnt_d = CntW'(RSV_TIMEOUT);
`endif
      end
      if (sc_leave) rsv_valid_d = 1'b0;
      if (snoop_valid && (snoop_addr[31:2] == rsv_addr_d)) rsv_valid_d = 1'b0;
      if (flush) rsv_valid_d = 1'b0;
   end

   // State and control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= StIdle;
         op_q         <= `AMO_OP_ADD_W;
         addr_q       <= '0;
         sc_fail_q    <= 1'b0;
         illegal_q    <= 1'b0;
         misaligned_q <= 1'b0;
         rsv_valid_q  <= 1'b0;
         rsv_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         sc_fail_q    <= sc_fail_d;
         illegal_q    <= illegal_d;
         misaligned_q <= misaligned_d;
         rsv_valid_q  <= rsv_valid_d;
         rsv_addr_q   <= rsv_addr_d;
      end
   end

`ifdef AMO_LRSC_TIMEOUT_EN
   // Reservation lifetime counter.
   always_ff @(posedge clk) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`endif

endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.

module tb_amo_sequencer;

`ifdef AMO_LRSC_TIMEOUT_EN
   localparam int unsigned Tmo = 4;
`else
   localparam int unsigned Tmo = 64;
`endif

   // alu_decoder encodings
   localparam logic [1:0] AluAdd = 2'd0;
   localparam logic [1:0] AluAmo = 2'd3;
   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpLr   = 4'd2;
   localparam logic [3:0] OpSc   = 4'd3;

   logic        clk, resetn, start, mem_ready, snoop_valid, flush;
   logic [4:0]  funct5;
   logic [31:0] addr, snoop_addr;
   logic        busy, done, illegal, misaligned, mem_valid, load_tmp, rd_we, rd_sel_sc, sc_fail;
   logic [3:0]  mem_wstrb;
   logic [1:0]  alu_op;
   logic [3:0]  amo_op;

   int n_checks = 0;
   int n_fail   = 0;

   amo_sequencer #(.RSV_TIMEOUT(Tmo)) dut (
      .clk(clk), .resetn(resetn), .start(start), .funct5(funct5), .addr(addr),
      .mem_ready(mem_ready), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
      .flush(flush), .busy(busy), .done(done), .illegal(illegal), .misaligned(misaligned),
      .mem_valid(mem_valid), .mem_wstrb(mem_wstrb), .load_tmp(load_tmp), .ALUOp(alu_op),
      .AMOop(amo_op), .rd_we(rd_we), .rd_sel_sc(rd_sel_sc), .sc_fail(sc_fail)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // funct5 -> AMOop table; index = AMOop value
   logic [4:0] f5_tab [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
                               5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100};

   function automatic int lookup(input logic [4:0] f);
      for (int i = 0; i < 11; i++) if (f5_tab[i] == f) return i;
      return -1;
   endfunction

   // ---------------- behavioural model ----------------
   // step: what the current instruction is doing this cycle
   typedef enum int {MIdle, MRead, MWrite, MWb} mstep_e;
   mstep_e      m_step;
   logic [3:0]  m_op;
   logic [31:0] m_addr;
   bit          m_known = 0, m_sc_fail, m_ill, m_mis;
   bit          m_rsv_valid;
   logic [31:0] m_rsv_addr;
   int          m_rsv_age;

   always @(posedge clk) begin
      if (!resetn) begin
         m_known = 1; m_step = MIdle; m_op = OpAdd; m_sc_fail = 0;
         m_ill = 0; m_mis = 0; m_rsv_valid = 0; m_rsv_age = 0;
      end else if (m_known) begin
         bit set_rsv, drop_rsv;
         int code;
         set_rsv = 0; drop_rsv = 0;
         m_ill = 0; m_mis = 0;
         code = lookup(funct5);
         if (m_step == MIdle) begin
            if (start) begin
               if (code < 0) m_ill = 1;
               else if (addr[1:0] != 2'b00) m_mis = 1;
               else begin
                  m_op = 4'(code); m_addr = addr;
                  if (m_op == OpSc) begin
                     m_sc_fail = !(m_rsv_valid && addr[31:2] == m_rsv_addr[31:2]);
                     drop_rsv = 1;
                     m_step = m_sc_fail ? MWb : MWrite;
                  end else m_step = MRead;
               end
            end
         end else if (m_step == MRead) begin
            if (mem_ready) begin
               if (m_op == OpLr) begin set_rsv = 1; m_step = MWb; end
               else m_step = MWrite;
            end
         end else if (m_step == MWrite) begin
            if (mem_ready) begin m_step = MWb; if (m_op == OpSc) m_sc_fail = 0; end
         end else m_step = MIdle;
`ifdef AMO_LRSC_TIMEOUT_EN
         if (m_rsv_valid) begin
            m_rsv_age++;
            if (m_rsv_age >= Tmo) m_rsv_valid = 0;
         end
`endif
         if (set_rsv) begin m_rsv_valid = 1; m_rsv_addr = m_addr; m_rsv_age = 0; end
         if (drop_rsv || flush) m_rsv_valid = 0;
         if (snoop_valid && snoop_addr[31:2] == m_rsv_addr[31:2]) m_rsv_valid = 0;
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (m_known) begin
         check("busy",       busy,       m_step != MIdle);
         check("done",       done,       m_step == MWb);
         check("rd_we",      rd_we,      m_step == MWb);
         check("mem_valid",  mem_valid,  m_step == MRead || m_step == MWrite);
         check("mem_wstrb",  mem_wstrb,  (m_step == MWrite) ? 4'hF : 4'h0);
         check("load_tmp",   load_tmp,   m_step == MRead && mem_ready);
         check("ALUOp",      alu_op,     (m_step == MWrite) ? AluAmo : AluAdd);
         check("AMOop",      amo_op,     (m_step == MIdle) ? OpAdd : m_op);
         check("rd_sel_sc",  rd_sel_sc,  m_step == MWb && m_op == OpSc);
         check("sc_fail",    sc_fail,    m_step == MWb && m_op == OpSc && m_sc_fail);
         check("illegal",    illegal,    m_ill);
         check("misaligned", misaligned, m_mis);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] f, input logic [31:0] a);
      start = 1'b1; funct5 = f; addr = a;
      cyc();
      start = 1'b0;
   endtask

   logic [31:0] bases [4] = '{32'h100, 32'h104, 32'h40, 32'h200};

   initial begin
      resetn = 1'b0; start = 1'b0; funct5 = '0; addr = '0; mem_ready = 1'b0;
      snoop_valid = 1'b0; snoop_addr = '0; flush = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_AMOop", amo_op, OpAdd);
      resetn = 1'b1;
      cyc();

      // 1: LR with two read waits, then a passing SC
      issue(5'b00010, 32'h100);
      @(negedge clk); check("t1_read_valid", mem_valid, 1'b1); check("t1_read_wstrb", mem_wstrb, 4'h0);
      cyc(); cyc(); mem_ready = 1'b1;
      @(negedge clk); check("t1_load_tmp", load_tmp, 1'b1);
      cyc(); mem_ready = 1'b0;
      @(negedge clk); check("t1_lr_done", done, 1'b1); check("t1_lr_sel", rd_sel_sc, 1'b0);
      cyc();
      issue(5'b00011, 32'h100); mem_ready = 1'b1;
      @(negedge clk); check("t1_sc_wstrb", mem_wstrb, 4'hF); check("t1_sc_aluop", alu_op, AluAmo);
      cyc(); mem_ready = 1'b0;
      @(negedge clk); check("t1_sc_done", done, 1'b1); check("t1_sc_fail", sc_fail, 1'b0);
      check("t1_sc_sel", rd_sel_sc, 1'b1);
      cyc();

      // 2: snoop to same word kills the reservation
      issue(5'b00010, 32'h100); mem_ready = 1'b1; cyc(); mem_ready = 1'b0; cyc();
      snoop_valid = 1'b1; snoop_addr = 32'h102; cyc(); snoop_valid = 1'b0;
      start = 1'b1; funct5 = 5'b00011; addr = 32'h100;
      @(negedge clk); check("t2_no_mem", mem_valid, 1'b0);
      cyc(); start = 1'b0;
      @(negedge clk); check("t2_done", done, 1'b1); check("t2_fail", sc_fail, 1'b1);
      check("t2_no_mem2", mem_valid, 1'b0);
      cyc();

      // 3: AMOADD read then write
      issue(5'b00000, 32'h40); mem_ready = 1'b1;
      @(negedge clk); check("t3_read_wstrb", mem_wstrb, 4'h0); check("t3_load", load_tmp, 1'b1);
      cyc();
      @(negedge clk); check("t3_wr_aluop", alu_op, AluAmo); check("t3_wr_amoop", amo_op, OpAdd);
      check("t3_wr_wstrb", mem_wstrb, 4'hF);
      cyc(); mem_ready = 1'b0;
      @(negedge clk); check("t3_done", done, 1'b1);
      cyc();

      // 4: illegal, misaligned, and illegal-over-misaligned priority
      issue(5'b00101, 32'h40);
      @(negedge clk); check("t4_illegal", illegal, 1'b1); check("t4_busy", busy, 1'b0);
      cyc();
      @(negedge clk); check("t4_ill_pulse", illegal, 1'b0);
      issue(5'b01000, 32'h41);
      @(negedge clk); check("t4_misaligned", misaligned, 1'b1); check("t4_busy2", busy, 1'b0);
      cyc();
      issue(5'b00110, 32'h43);
      @(negedge clk); check("t4_prio_ill", illegal, 1'b1); check("t4_prio_mis", misaligned, 1'b0);
      cyc();

      // 5: reset during a stalled WRITE
      issue(5'b00010, 32'h200); mem_ready = 1'b1; cyc(); mem_ready = 1'b0; cyc();
      issue(5'b00001, 32'h80); mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
      @(negedge clk); check("t5_in_write", mem_wstrb, 4'hF);
      resetn = 1'b0; cyc(); resetn = 1'b1;
      @(negedge clk); check("t5_idle", busy, 1'b0); check("t5_mem", mem_valid, 1'b0);
      issue(5'b00011, 32'h200);
      @(negedge clk); check("t5_rsv_gone", sc_fail, 1'b1);
      cyc();

`ifdef AMO_LRSC_TIMEOUT_EN
      // 6: reservation expires
      issue(5'b00010, 32'h300); mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
      repeat (5) cyc();
      issue(5'b00011, 32'h300);
      @(negedge clk); check("t6_timeout", sc_fail, 1'b1);
      cyc();
`endif

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         resetn      = ($urandom_range(0, 199) != 0);
         start       = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) funct5 = 5'($urandom);
         else if ($urandom_range(0, 1) == 0) funct5 = ($urandom_range(0, 1) == 0) ? 5'b00010
                                                                                   : 5'b00011;
         else funct5 = f5_tab[$urandom_range(0, 10)];
         addr = bases[$urandom_range(0, 3)];
         if ($urandom_range(0, 15) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         mem_ready   = ($urandom_range(0, 1) == 0);
         snoop_valid = ($urandom_range(0, 7) == 0);
         snoop_addr  = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
         flush       = ($urandom_range(0, 31) == 0);
         cyc();
      end
      resetn = 1'b1; start = 1'b0; snoop_valid = 1'b0; flush = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
